// File: rtl/vdp1_line_engine_if.sv
// vdp1_line_engine_if: pixel stream from the line engine to its consumer.
// The master drives the pixel and its metadata, the slave returns pix_ready.
interface vdp1_line_engine_if #(
  parameter int COORD_W = 11,
  parameter int CNT_W   = 12
);
  logic                      pix_valid;
  logic                      pix_ready;
  logic signed [COORD_W-1:0] pix_x;
  logic signed [COORD_W-1:0] pix_y;
  logic                      pix_last;
  logic [CNT_W-1:0]          pix_count;

  modport master (
    output pix_valid,
    output pix_x,
    output pix_y,
    output pix_last,
    output pix_count,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_x,
    input  pix_y,
    input  pix_last,
    input  pix_count,
    output pix_ready
  );
endinterface

// File: rtl/vdp1_line_engine.sv
// vdp1_line_engine: signed Bresenham line stepper with a valid/ready pixel stream.
// Define VDP1_LINE_CLIP_EN to suppress points outside the sampled clip window.
module vdp1_line_engine #(
  parameter int COORD_W = 11,
  parameter int CNT_W   = 12
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  input  logic signed [COORD_W-1:0] clip_xmin,
  input  logic signed [COORD_W-1:0] clip_ymin,
  input  logic signed [COORD_W-1:0] clip_xmax,
  input  logic signed [COORD_W-1:0] clip_ymax,
  output logic                      busy,
  output logic [CNT_W-1:0]          length,
  output logic                      done,
  vdp1_line_engine_if.master        pix
);

  localparam int EW = COORD_W + 2;

  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [EW-1:0]      ext_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DONE
  } state_t;

  localparam crd_t ONE = crd_t'(1);

  function automatic ext_t sext(input crd_t v);
    return {{2{v[COORD_W-1]}}, v};
  endfunction

  state_t           state_q, state_d;
  crd_t             x0_q, x0_d;
  crd_t             y0_q, y0_d;
  crd_t             x1_q, x1_d;
  crd_t             y1_q, y1_d;
  ext_t             dx_q, dx_d;
  ext_t             dy_q, dy_d;
  ext_t             err_q, err_d;
  logic             sxn_q, sxn_d;
  logic             syn_q, syn_d;
  crd_t             px_q, px_d;
  crd_t             py_q, py_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  // Deltas are taken straight from the ports so length is ready
  // in the cycle after acceptance.
  ext_t ddx, ddy, adx, ady, amax;
  logic [CNT_W-1:0] len_acc;

  assign ddx     = sext(x1) - sext(x0);
  assign ddy     = sext(y1) - sext(y0);
  assign adx     = ddx[EW-1] ? -ddx : ddx;
  assign ady     = ddy[EW-1] ? -ddy : ddy;
  assign amax    = (adx > ady) ? adx : ady;
  assign len_acc = CNT_W'($unsigned(amax));

  ext_t e2, err_x, err_n;
  logic stx, sty;
  crd_t nx, ny;

  assign e2    = {err_q[EW-2:0], 1'b0};
  assign stx   = (e2 >= -dy_q);
  assign sty   = (e2 <= dx_q);
  assign err_x = stx ? err_q - dy_q : err_q;
  assign err_n = sty ? err_x + dx_q : err_x;
  assign nx    = !stx ? px_q :
                 sxn_q ? px_q - ONE : px_q + ONE;
  assign ny    = !sty ? py_q :
                 syn_q ? py_q - ONE : py_q + ONE;

  // Next point to present: the start point out of SETUP,
  // otherwise the stepped point.
  crd_t cand_x, cand_y;
  logic cand_end, cand_in, at_end;

  assign cand_x   = (state_q == S_SETUP) ? x0_q : nx;
  assign cand_y   = (state_q == S_SETUP) ? y0_q : ny;
  assign cand_end = (cand_x == x1_q) && (cand_y == y1_q);
  assign at_end   = (px_q == x1_q) && (py_q == y1_q);

`ifdef VDP1_LINE_CLIP_EN
  crd_t cxl_q, cxl_d;
  crd_t cyl_q, cyl_d;
  crd_t cxh_q, cxh_d;
  crd_t cyh_q, cyh_d;

  assign cand_in = (cand_x >= cxl_q) && (cand_x <= cxh_q) &&
                   (cand_y >= cyl_q) && (cand_y <= cyh_q);

  always_comb begin
    cxl_d = cxl_q;
    cyl_d = cyl_q;
    cxh_d = cxh_q;
    cyh_d = cyh_q;
    if (state_q == S_IDLE && start) begin
      cxl_d = clip_xmin;
      cyl_d = clip_ymin;
      cxh_d = clip_xmax;
      cyh_d = clip_ymax;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cxl_q <= '0;
      cyl_q <= '0;
      cxh_q <= '0;
      cyh_q <= '0;
    end else begin
      cxl_q <= cxl_d;
      cyl_q <= cyl_d;
      cxh_q <= cxh_d;
      cyh_q <= cyh_d;
    end
  end
`else
  logic unused_clip;

  assign cand_in     = 1'b1;
  assign unused_clip = ^{clip_xmin, clip_ymin,
                         clip_xmax, clip_ymax};
`endif

  logic step, acc_pix;

  // A suppressed point never waits for the consumer.
  assign step    = valid_q ? pix.pix_ready : 1'b1;
  assign acc_pix = valid_q & pix.pix_ready;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    px_d    = px_q;
    py_d    = py_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          dx_d    = adx;
          dy_d    = ady;
          sxn_d   = ddx[EW-1];
          syn_d   = ddy[EW-1];
          len_d   = len_acc;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RUN;
          err_d   = dx_q - dy_q;
          px_d    = x0_q;
          py_d    = y0_q;
          valid_d = cand_in;
          last_d  = cand_in & cand_end;
        end
      end
      S_RUN: begin
        if (acc_pix) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (step) begin
          if (at_end) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            px_d    = nx;
            py_d    = ny;
            err_d   = err_n;
            valid_d = cand_in;
            last_d  = cand_in & cand_end;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      px_q    <= px_d;
      py_q    <= py_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign length        = len_q;
  assign pix.pix_valid = valid_q;
  assign pix.pix_x     = px_q;
  assign pix.pix_y     = py_q;
  assign pix.pix_last  = last_q;
  assign pix.pix_count = cnt_q;

endmodule
